// File: rtl/uart_echo_responder_if.sv
// -----------------------------------------------------------------------------
// uart_echo_responder_if
// Groups the uart-facing handshake signals of the echo responder.
//   rx_rdy / rx_data / rx_rdy_clr : receive side (uart rdy, dout, rdy_clr)
//   tx_busy / tx_din / tx_wr_en   : transmit side (uart tx_busy, din, wr_en)
//   fifo_level / overflow_cnt     : status outputs of the responder
// Modports:
//   master : the echo responder (drives rdy_clr, din, wr_en and status)
//   slave  : the uart / host side (drives rdy, dout, tx_busy)
// DEPTH must match the DEPTH of the responder it is bound to.
// -----------------------------------------------------------------------------
interface uart_echo_responder_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          rx_rdy_clr;
    logic          tx_busy;
    logic [7:0]    tx_din;
    logic          tx_wr_en;
    logic [LW-1:0] fifo_level;
    logic [7:0]    overflow_cnt;

    modport master (
        input  rx_rdy, rx_data, tx_busy,
        output rx_rdy_clr, tx_din, tx_wr_en, fifo_level, overflow_cnt
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy,
        input  rx_rdy_clr, tx_din, tx_wr_en, fifo_level, overflow_cnt
    );
endinterface

// File: rtl/uart_echo_responder.sv
// -----------------------------------------------------------------------------
// uart_echo_responder
// On-chip loopback partner for the uart: every byte flagged by the uart
// receiver is pushed into a small FIFO and echoed back (XORed with XOR_MASK)
// through the uart transmitter, paced by tx_busy.
// Ports:
//   clk_50m : system clock
//   rst     : synchronous reset, active-high (not forwarded to the uart)
//   bus     : uart_echo_responder_if.master
//             rx_rdy/rx_data in, rx_rdy_clr out (one-cycle pulse)
//             tx_busy in, tx_din/tx_wr_en out (wr_en one-cycle pulse)
//             fifo_level out (entries held), overflow_cnt out (saturating)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module uart_echo_responder #(
    parameter int         DEPTH        = 4,
    parameter logic [7:0] XOR_MASK     = 8'h00,
    parameter int         BUSY_TIMEOUT = 16
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    uart_echo_responder_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_WAIT = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_t;

    rx_state_t     rx_state_q, rx_state_d;
    tx_state_t     tx_state_q, tx_state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    ovf_q, ovf_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_clr_q, rx_clr_d;
    logic [7:0]    tx_din_q, tx_din_d;
    logic          tx_wr_q, tx_wr_d;

    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;

    assign full_s  = (level_q == LW'(DEPTH));
    assign empty_s = (level_q == {LW{1'b0}});

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push_s  = push_req_s && (!full_s || pop_s);

    // Receive handshake: consume each rdy assertion exactly once.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_clr_d   = 1'b0;
        push_req_s = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (bus.rx_rdy) begin
                    push_req_s = 1'b1;
                    rx_clr_d   = 1'b1;
                    rx_state_d = RX_WAIT;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_WAIT: begin
                // The uart may drop rdy a cycle or more after rdy_clr.
                if (!bus.rx_rdy) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Transmit pacing: write the head byte, then track the uart busy window.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_wr_d    = 1'b0;
        tx_din_d   = tx_din_q;
        tmo_d      = tmo_q;
        pop_s      = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tmo_d = {TW{1'b0}};
                if (!empty_s && !bus.tx_busy) begin
                    pop_s      = 1'b1;
                    tx_wr_d    = 1'b1;
                    tx_din_d   = mem_q[rd_ptr_q] ^ XOR_MASK;
                    tx_state_d = TX_WAIT_BUSY;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_WAIT_BUSY: begin
                // A uart that never raises busy must not stall the echo path.
                if (bus.tx_busy) begin
                    tmo_d      = {TW{1'b0}};
                    tx_state_d = TX_WAIT_DONE;
                end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                    tmo_d      = {TW{1'b0}};
                    tx_state_d = TX_IDLE;
                end else begin
                    tmo_d      = tmo_q + TW'(1'b1);
                    tx_state_d = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_WAIT_DONE;
                end
            end
            default: begin
                tmo_d      = {TW{1'b0}};
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // FIFO pointer, fill level and saturating drop counter update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
        if (push_req_s && !push_s && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
            ovf_q      <= 8'h00;
            tmo_q      <= {TW{1'b0}};
            rx_clr_q   <= 1'b0;
            tx_din_q   <= 8'h00;
            tx_wr_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            rx_clr_q   <= rx_clr_d;
            tx_din_q   <= tx_din_d;
            tx_wr_q    <= tx_wr_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_50m) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rx_rdy_clr   = rx_clr_q;
    assign bus.tx_din       = tx_din_q;
    assign bus.tx_wr_en     = tx_wr_q;
    assign bus.fifo_level   = level_q;
    assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_responder
// Two responders share one stimulus: dut0 with XOR_MASK=8'h00 and dut1 with
// XOR_MASK=8'hFF, so every echoed byte of dut1 is the complement of dut0's.
// tx_busy is the OR of a directly forced level and a small uart emulation
// that raises busy for emu_len cycles after each observed write.
// -----------------------------------------------------------------------------
module tb_uart_echo_responder;
    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       busy_force = 1'b0;
    logic       busy_emu = 1'b0;
    logic       emu_en = 1'b0;
    int         emu_len = 3;
    int         cyc = 0;

    int errors = 0;
    int checks = 0;

    logic [7:0] wr_q [$];
    logic [7:0] wrb_q [$];
    int         wr_cyc [$];

    uart_echo_responder_if #(.DEPTH(4)) ifa ();
    uart_echo_responder_if #(.DEPTH(4)) ifb ();

    assign ifa.rx_rdy  = rx_rdy;
    assign ifa.rx_data = rx_data;
    assign ifa.tx_busy = busy_force | busy_emu;
    assign ifb.rx_rdy  = rx_rdy;
    assign ifb.rx_data = rx_data;
    assign ifb.tx_busy = busy_force | busy_emu;

    uart_echo_responder #(.DEPTH(4), .XOR_MASK(8'h00), .BUSY_TIMEOUT(16)) dut0 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (ifa)
    );

    uart_echo_responder #(.DEPTH(4), .XOR_MASK(8'hFF), .BUSY_TIMEOUT(16)) dut1 (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (ifb)
    );

    always #5 clk_50m = ~clk_50m;

    always @(posedge clk_50m) cyc <= cyc + 1;

    // Record every write pulse, sampled mid-cycle.
    always @(negedge clk_50m) begin
        if (ifa.tx_wr_en) begin
            wr_q.push_back(ifa.tx_din);
            wrb_q.push_back(ifb.tx_din);
            wr_cyc.push_back(cyc);
        end
    end

    // Uart transmitter emulation: busy for emu_len cycles after each write.
    initial begin
        forever begin
            @(negedge clk_50m);
            if (emu_en && ifa.tx_wr_en) begin
                busy_emu = 1'b1;
                repeat (emu_len) @(negedge clk_50m);
                busy_emu = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Host-side uart receiver: hold rdy until rdy_clr, then drop it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        do begin
            tick();
            n++;
        end while (!ifa.rx_rdy_clr && n < 8);
        chk("rdy_clr_seen", {31'd0, ifa.rx_rdy_clr}, 32'd1);
        rx_rdy = 1'b0;
        tick();
    endtask

    task automatic wait_writes(input int n, input int bound);
        int k;
        k = 0;
        while (wr_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk("write_wait", {31'd0, (wr_q.size() >= n)}, 32'd1);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] gotb;
        int         c0;

        vecs[0] = '{data: 8'h5A, exp0: 8'h5A, exp1: 8'hA5};
        vecs[1] = '{data: 8'h0F, exp0: 8'h0F, exp1: 8'hF0};
        vecs[2] = '{data: 8'h00, exp0: 8'h00, exp1: 8'hFF};
        vecs[3] = '{data: 8'hFF, exp0: 8'hFF, exp1: 8'h00};
        vecs[4] = '{data: 8'h3C, exp0: 8'h3C, exp1: 8'hC3};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_clr",   {31'd0, ifa.rx_rdy_clr}, 32'd0);
        chk("rst_wr",    {31'd0, ifa.tx_wr_en}, 32'd0);
        chk("rst_din",   {24'd0, ifa.tx_din}, 32'd0);
        chk("rst_level", {29'd0, ifa.fifo_level}, 32'd0);
        chk("rst_ovf",   {24'd0, ifa.overflow_cnt}, 32'd0);
        chk("rst_din_m", {24'd0, ifb.tx_din}, 32'd0);
        rst = 1'b0;
        tick();

        // Single-byte echo, exact cycle timing, both masks
        emu_en  = 1'b1;
        emu_len = 3;
        for (int i = 0; i < 5; i++) begin
            rx_data = vecs[i].data;
            rx_rdy  = 1'b1;
            tick();
            chk("clr_k",      {31'd0, ifa.rx_rdy_clr}, 32'd1);
            chk("wr_early",   {31'd0, ifa.tx_wr_en}, 32'd0);
            chk("level_k",    {29'd0, ifa.fifo_level}, 32'd1);
            rx_rdy = 1'b0;
            tick();
            chk("clr_pulse",  {31'd0, ifa.rx_rdy_clr}, 32'd0);
            chk("wr_k1",      {31'd0, ifa.tx_wr_en}, 32'd1);
            chk("din",        {24'd0, ifa.tx_din}, {24'd0, vecs[i].exp0});
            chk("din_mask",   {24'd0, ifb.tx_din}, {24'd0, vecs[i].exp1});
            chk("level_k1",   {29'd0, ifa.fifo_level}, 32'd0);
            tick();
            chk("wr_pulse",   {31'd0, ifa.tx_wr_en}, 32'd0);
            chk("din_hold",   {24'd0, ifa.tx_din}, {24'd0, vecs[i].exp0});
            repeat (6) tick();
        end

        // Burst with busy held: four stored, two dropped
        emu_len    = 10;
        busy_force = 1'b1;
        tick();
        wr_q.delete();
        wrb_q.delete();
        wr_cyc.delete();
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i));
        end
        chk("burst_level",  {29'd0, ifa.fifo_level}, 32'd4);
        chk("burst_ovf",    {24'd0, ifa.overflow_cnt}, 32'd2);
        chk("burst_ovf_m",  {24'd0, ifb.overflow_cnt}, 32'd2);
        chk("burst_nowr",   wr_q.size(), 32'd0);
        busy_force = 1'b0;
        wait_writes(4, 200);
        for (int i = 1; i <= 4; i++) begin
            if (wr_q.size() > 0) begin
                got  = wr_q.pop_front();
                gotb = wrb_q.pop_front();
                chk("burst_order",   {24'd0, got}, i);
                chk("burst_order_m", {24'd0, gotb}, {24'd0, ~8'(i)});
            end
        end
        repeat (20) tick();
        chk("burst_extra",  wr_q.size(), 32'd0);
        chk("burst_drain",  {29'd0, ifa.fifo_level}, 32'd0);

        // Busy timeout: uart never raises busy
        emu_en = 1'b0;
        wr_q.delete();
        wrb_q.delete();
        wr_cyc.delete();
        send_byte(8'hA5);
        send_byte(8'hA6);
        wait_writes(2, 60);
        repeat (30) tick();
        chk("tmo_count", wr_q.size(), 32'd2);
        if (wr_q.size() >= 2) begin
            chk("tmo_first",  {24'd0, wr_q[0]}, 32'h0A5);
            chk("tmo_second", {24'd0, wr_q[1]}, 32'h0A6);
            chk("tmo_gap",    wr_cyc[1] - wr_cyc[0], 32'd17);
        end

        // Reset while three bytes wait and the uart is busy
        wr_q.delete();
        wrb_q.delete();
        wr_cyc.delete();
        send_byte(8'h11);
        busy_force = 1'b1;
        send_byte(8'h12);
        send_byte(8'h13);
        send_byte(8'h14);
        chk("pre_rst_level", {29'd0, ifa.fifo_level}, 32'd3);
        chk("pre_rst_ovf",   {24'd0, ifa.overflow_cnt}, 32'd2);
        rst     = 1'b1;
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_level", {29'd0, ifa.fifo_level}, 32'd0);
        chk("mid_rst_wr",    {31'd0, ifa.tx_wr_en}, 32'd0);
        chk("mid_rst_ovf",   {24'd0, ifa.overflow_cnt}, 32'd0);
        chk("mid_rst_clr",   {31'd0, ifa.rx_rdy_clr}, 32'd0);
        tick();
        chk("post_rst_clr",   {31'd0, ifa.rx_rdy_clr}, 32'd1);
        chk("post_rst_level", {29'd0, ifa.fifo_level}, 32'd1);
        rx_rdy = 1'b0;
        repeat (10) tick();
        chk("busy_nowr", wr_q.size(), 32'd1);
        emu_en     = 1'b1;
        emu_len    = 10;
        busy_force = 1'b0;
        wait_writes(2, 40);
        if (wr_q.size() >= 2) begin
            chk("post_rst_echo", {24'd0, wr_q[1]}, 32'h077);
        end
        repeat (15) tick();

        // Loopback of every byte value
        wr_q.delete();
        wrb_q.delete();
        wr_cyc.delete();
        for (int b = 0; b < 256; b++) begin
            send_byte(8'(b));
            c0 = 0;
            while (wr_q.size() == 0 && c0 < 40) begin
                tick();
                c0++;
            end
            if (wr_q.size() == 0) begin
                chk("loop_timeout", 32'd0, 32'd1);
            end else begin
                got  = wr_q.pop_front();
                gotb = wrb_q.pop_front();
                chk("loop_echo",   {24'd0, got}, b);
                chk("loop_echo_m", {24'd0, gotb}, {24'd0, ~8'(b)});
            end
        end
        repeat (20) tick();
        chk("loop_ovf",   {24'd0, ifa.overflow_cnt}, 32'd0);
        chk("loop_level", {29'd0, ifa.fifo_level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
- Hardware far end of the UART byte link: consumes received bytes from the uart receive interface (rdy/dout/rdy_clr) and echoes them back through the uart transmit interface (din/wr_en/tx_busy).
- Optional XOR transform is applied on the way out.
- Small FIFO decouples receive bursts from transmit pacing.
- Sits beside the uart instance in the top level and serves as the on-chip loopback partner for host-side byte-stream tests.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XOR_MASK, 8'h00, value XORed into every echoed byte.
- BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after a write before returning to idle.

Ports:
- clk_50m  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_rdy  input  1  uart rdy; byte available, level held until cleared
- rx_data  input  8  uart dout
- rx_rdy_clr  output  1  uart rdy_clr; one-cycle pulse
- tx_busy  input  1  uart tx_busy
- tx_din  output  8  uart din
- tx_wr_en  output  1  uart wr_en; one-cycle pulse
- fifo_level  output  clog2(DEPTH)+1  entries currently held (3 bits at default)
- overflow_cnt  output  8  dropped-byte count, saturating

Behaviour:
- Reset (rst high at a clk_50m edge):
  - All outputs 0, FIFO empty, overflow_cnt 0, both FSMs idle.
  - Reset is not propagated to the uart. A byte still flagged by rx_rdy after reset is captured normally once rst is low.
  - An in-flight uart transmission completes untouched; TX_IDLE gates on tx_busy.
- RX FSM:
  - RX_IDLE: at an edge with rx_rdy=1, push rx_data into the FIFO, set rx_rdy_clr=1 for exactly one cycle, go to RX_WAIT.
  - RX_WAIT: rx_rdy_clr=0; hold until rx_rdy=0, then go to RX_IDLE. Each rdy assertion is therefore consumed exactly once, even if the uart drops rdy late.
  - Full FIFO: the push is accepted only if the FIFO is not full, or a pop occurs on the same edge. Otherwise the byte is dropped, rx_rdy_clr still pulses, and overflow_cnt increments, saturating at 8'hFF.
- TX FSM:
  - TX_IDLE: at an edge with FIFO non-empty and tx_busy=0, register tx_din = head ^ XOR_MASK, set tx_wr_en=1 for one cycle, pop, go to TX_WAIT_BUSY.
  - TX_WAIT_BUSY: tx_wr_en=0. Go to TX_WAIT_DONE on tx_busy=1. If tx_busy stays 0 for BUSY_TIMEOUT cycles, return to TX_IDLE; the byte counts as sent.
  - TX_WAIT_DONE: go to TX_IDLE on tx_busy=0.
  - tx_din holds its last value between writes.
- Latency:
  - rx_rdy first sampled high at edge k: rx_rdy_clr is high during cycle k..k+1 and the byte is in the FIFO after edge k.
  - With the FIFO otherwise empty and tx_busy=0, tx_wr_en is high during cycle k+1..k+2. Minimum receive-to-write latency is 2 cycles.
- FIFO:
  - Circular buffer with wrap-around read/write pointers (clog2(DEPTH) bits).
  - Simultaneous push and pop leaves fifo_level unchanged.
  - fifo_level never exceeds DEPTH and never underflows.
  - Bytes are echoed in arrival order.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Single byte: after reset, hold rx_rdy=1 with rx_data=8'h5A until rx_rdy_clr is seen. Required: rx_rdy_clr is a one-cycle pulse; tx_wr_en pulses exactly 2 cycles after rx_rdy was first sampled; tx_din=8'h5A; fifo_level returns to 0.
- Mask: XOR_MASK=8'hFF, send 8'h0F. Required: tx_din=8'hF0.
- Burst/overflow: hold tx_busy=1, deliver 8'h01..8'h06 as six rdy/clr handshakes. Required:
  - fifo_level=4, overflow_cnt=2.
  - Release tx_busy, emulating busy for 10 cycles after each write: tx_din sequence is 01,02,03,04; then fifo_level=0.
- Busy timeout: send 8'hA5 with tx_busy tied 0. Required: one tx_wr_en pulse; TX_IDLE is re-entered after 16 cycles; a second byte 8'hA6 is then echoed.
- Loopback with the uart module: rx tied to tx on the host side, send 8'h00..8'hFF. Required: every echoed byte equals the sent byte and overflow_cnt=0.
- Reset mid-operation: assert rst for 1 cycle while 3 bytes are queued and in TX_WAIT_DONE. Required: fifo_level=0, tx_wr_en=0, overflow_cnt=0 the next cycle; no write is issued while tx_busy=1.
